// File: rtl/cam_pixel_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cam_pixel_capture                                            |
// | Description : Samples an 8-bit camera bus in the system clock domain,      |
// |               pairs bytes into RGB565 pixels and drives a RAM write port.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cam_pixel_capture #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int AW    = 17,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          cam_pclk,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wr,
    output logic          frame_done,
    output logic          busy
);

    localparam int              c_COL_W    = $clog2(IMG_W + 1);
    localparam int              c_ROW_W    = $clog2(IMG_H + 1);
    localparam logic [c_COL_W-1:0] c_COL_MAX  = c_COL_W'(IMG_W);
    localparam logic [c_ROW_W-1:0] c_ROW_MAX  = c_ROW_W'(IMG_H);
    localparam logic [AW-1:0]   c_ADDR_MAX = AW'(IMG_W * IMG_H - 1);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE  = 2'd2;
    localparam logic [1:0] c_ST_DONE     = 2'd3;

    localparam logic c_PH_HI = 1'b0;
    localparam logic c_PH_LO = 1'b1;

    logic       r_pclk_s1, r_pclk_s2, r_pclk_d;
    logic       r_vsync_s1, r_vsync_s2, r_vsync_d;
    logic       r_href_s1, r_href_s2, r_href_d;
    logic [7:0] r_data_s1, r_data_s2, r_data_d;
    logic       r_pclk_rise, r_vsync_rise, r_vsync_fall, r_href_fall;

    logic [1:0]         r_state;
    logic               r_phase;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [AW-1:0]      r_mem_addr;
    logic [DW-1:0]      r_mem_data;
    logic               r_mem_wr;
    logic               r_frame_done;
    logic               r_busy;

    logic w_byte_valid;

    // Edge flags are registered, so the *_d copies are the level values aligned with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pclk_s1    <= 1'b0;
            r_pclk_s2    <= 1'b0;
            r_pclk_d     <= 1'b0;
            r_vsync_s1   <= 1'b0;
            r_vsync_s2   <= 1'b0;
            r_vsync_d    <= 1'b0;
            r_href_s1    <= 1'b0;
            r_href_s2    <= 1'b0;
            r_href_d     <= 1'b0;
            r_data_s1    <= 8'd0;
            r_data_s2    <= 8'd0;
            r_data_d     <= 8'd0;
            r_pclk_rise  <= 1'b0;
            r_vsync_rise <= 1'b0;
            r_vsync_fall <= 1'b0;
            r_href_fall  <= 1'b0;
        end else begin
            r_pclk_s1    <= cam_pclk;
            r_pclk_s2    <= r_pclk_s1;
            r_pclk_d     <= r_pclk_s2;
            r_vsync_s1   <= cam_vsync;
            r_vsync_s2   <= r_vsync_s1;
            r_vsync_d    <= r_vsync_s2;
            r_href_s1    <= cam_href;
            r_href_s2    <= r_href_s1;
            r_href_d     <= r_href_s2;
            r_data_s1    <= cam_data;
            r_data_s2    <= r_data_s1;
            r_data_d     <= r_data_s2;
            r_pclk_rise  <= r_pclk_s2 & ~r_pclk_d;
            r_vsync_rise <= r_vsync_s2 & ~r_vsync_d;
            r_vsync_fall <= ~r_vsync_s2 & r_vsync_d;
            r_href_fall  <= ~r_href_s2 & r_href_d;
        end
    end

    assign w_byte_valid = r_pclk_rise & r_href_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_phase      <= c_PH_HI;
            r_col        <= '0;
            r_row        <= '0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_wr     <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_mem_wr     <= 1'b0;
            r_frame_done <= 1'b0;

            // Saturating advance keeps the address inside the frame buffer.
            if (r_mem_wr && (r_mem_addr != c_ADDR_MAX)) begin
                r_mem_addr <= r_mem_addr + AW'(1);
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (enable) begin
                        r_state <= c_ST_WAIT_SOF;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_WAIT_SOF: begin
                    if (r_vsync_fall) begin
                        r_mem_addr <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_phase    <= c_PH_HI;
                        r_state    <= c_ST_CAPTURE;
                    end
                end
                c_ST_CAPTURE: begin
                    if (r_vsync_rise) begin
                        r_state      <= c_ST_DONE;
                        r_frame_done <= 1'b1;
                    end else if (r_href_fall) begin
                        r_col   <= '0;
                        r_phase <= c_PH_HI;
                        if (r_row != c_ROW_MAX) begin
                            r_row <= r_row + c_ROW_W'(1);
                        end
                    end else if (w_byte_valid) begin
                        if (r_phase == c_PH_HI) begin
                            r_mem_data[DW-1 -: 8] <= r_data_d;
                            r_phase               <= c_PH_LO;
                        end else begin
                            r_mem_data[7:0] <= r_data_d;
                            r_phase         <= c_PH_HI;
                            if (r_col != c_COL_MAX) begin
                                r_col <= r_col + c_COL_W'(1);
                            end
                            if ((r_col < c_COL_MAX) && (r_row < c_ROW_MAX)) begin
                                r_mem_wr <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign mem_wr     = r_mem_wr;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Upstream stage of buffer_ram_dp in the camera path.
- Samples the 8-bit camera bus (pclk/href/vsync/data), assembles RGB565 pixels from byte pairs, and drives the RAM write port (addr_in/data_in/regwrite).
- Runs entirely in the system clock domain. Camera pclk is treated as a synchronized data signal, not a clock.

Parameters:
- IMG_W, 160, pixels written per line; extra pixels in a line are dropped.
- IMG_H, 120, lines written per frame; extra lines are dropped.
- AW, 17, address width; must match buffer_ram_dp addr_in.
- DW, 16, pixel width; must match buffer_ram_dp data_in.

Ports:
- clk  in  1  system clock; ≥4x cam_pclk frequency.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  arms capture; sampled only in IDLE.
- cam_pclk  in  1  camera pixel clock, asynchronous to clk.
- cam_vsync  in  1  frame sync; high = vertical blanking.
- cam_href  in  1  line valid; high = byte valid on pclk rise.
- cam_data  in  8  camera byte.
- mem_addr  out  AW  RAM write address (to addr_in).
- mem_data  out  DW  RAM write data (to data_in).
- mem_wr  out  1  one-cycle write strobe (to regwrite).
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Input synchronization:
  - cam_pclk, cam_vsync, cam_href, and cam_data each pass through a 2-flop synchronizer, so all inputs stay aligned.
  - pclk_rise = sync_pclk & ~prev_pclk.
  - Falling and rising edges of vsync and href are detected the same way from the synchronized signals.
- Reset values:
  - mem_addr=0, mem_data=0, mem_wr=0, frame_done=0, busy=0.
  - state=IDLE; byte-phase=HI; column and row counters=0; synchronizer flops=0.
- FSM states:
  - IDLE: if enable=1, go to WAIT_SOF.
  - WAIT_SOF: on a synchronized vsync falling edge, clear the address, column and row counters, then go to CAPTURE.
  - CAPTURE: runs the byte logic below. On a vsync rising edge, go to DONE.
  - DONE: assert frame_done for exactly one cycle, then go to IDLE.
- Byte logic in CAPTURE (acts only on pclk_rise with sync_href=1):
  - Phase HI: latch the byte into mem_data[15:8] and set phase=LO.
  - Phase LO: place the byte in mem_data[7:0] and set phase=HI.
  - Phase LO also issues a write when column<IMG_W and row<IMG_H.
- Write timing:
  - mem_wr is registered and high for one clk, in the cycle after the pclk_rise that carries the LO byte.
  - mem_addr and mem_data are stable during that cycle.
  - mem_addr increments by 1 in the cycle after mem_wr.
  - The column counter increments on every completed pixel, whether it was written or dropped.
- Latency: 4 clk from the camera pclk edge to mem_wr high (2 sync stages, 1 edge detect, 1 output register).
- href falling edge:
  - column clears to 0 and phase resets to HI; a dangling HI byte is discarded.
  - row increments, saturating at IMG_H.
- Address bound:
  - mem_addr never exceeds IMG_W*IMG_H-1 and never wraps within a frame.
  - Excess pixels and lines are silently dropped.
- A short frame (vsync rise before IMG_H lines) still produces frame_done. RAM contents beyond the last written address are unchanged.
- Simultaneous events:
  - vsync rise takes priority over a pclk_rise in the same cycle; that byte is discarded.
  - A pending mem_wr strobe always completes.
- enable deasserted mid-frame: ignored; the current frame finishes.
- rst asserted mid-operation: takes effect immediately. mem_wr=0 in the same instant; the partially written frame is abandoned.
- busy=1 in WAIT_SOF, CAPTURE and DONE.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst mid-simulation, then hold enable=0 while toggling the camera inputs.
  - Required: all outputs are 0 and no mem_wr ever appears.
- Basic line:
  - Stimulus: enable=1, vsync fall, one href line with bytes AA,AA,86,42,FF,FF,97,53.
  - Required: exactly 4 mem_wr pulses, writing addr 0..3 with data AAAA, 8642, FFFF, 9753.
  - Read back through buffer_ram_dp with regread and confirm the values.
- Odd byte:
  - Stimulus: a line of 3 bytes 12,34,56, then a line of 2 bytes 9A,BC.
  - Required: only addr 0=1234 and addr 1=9ABC are written; byte 56 is discarded.
- Overflow (IMG_W=4, IMG_H=2):
  - Stimulus: 3 lines of 6 pixels each.
  - Required: exactly 8 writes to addr 0..7 and mem_addr never reaches 8; frame_done pulses once after vsync rises.
- Collision:
  - Stimulus: vsync rise coincident with a LO-byte pclk edge.
  - Required: no write for that pixel; frame_done is high for exactly 1 clk; state returns to IDLE.
- Reset mid-frame:
  - Stimulus: assert rst after 2 pixels of a line, release it, then run a full frame.
  - Required: the new frame starts writing at addr 0 with no spurious mem_wr.
